// File: rtl/mux_scan_seq_if.sv
// Downstream valid/ready channel carrying one assembled scan word.
interface mux_scan_seq_if;
  logic [15:0] dout;
  logic        valid;
  logic        ready;

  modport master (output dout, output valid, input ready);
  modport slave  (input dout, input valid, output ready);
endinterface

// File: rtl/mux_scan_seq.sv
// Steps a 16:1 mux select through all channels, samples y after a settle
// delay, and offers the assembled 16-bit word over a valid/ready channel.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; si parked at 0
// S_SETTLE | si driven, counting SETTLE cycles for the mux output
// S_SAMPLE | capture y into acc[si]; advance si or finish the scan
// S_DONE   | dout valid, waiting for ready; si parked at 15
module mux_scan_seq #(
  parameter int unsigned SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          y,
  output logic [3:0]    si,
  output logic          busy,
  mux_scan_seq_if.master dn
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // SETTLE never enters S_SETTLE when zero, so the compare value is moot there.
  localparam logic [3:0] CNT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t      state, state_nxt;
  logic [3:0]  si_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] acc, acc_nxt;
  logic [15:0] dout_q, dout_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      si     <= '0;
      cnt    <= '0;
      acc    <= '0;
      dout_q <= '0;
    end else begin
      state  <= state_nxt;
      si     <= si_nxt;
      cnt    <= cnt_nxt;
      acc    <= acc_nxt;
      dout_q <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    si_nxt    = si;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    dout_nxt  = dout_q;
    case (state)
      S_IDLE: begin
        si_nxt  = 4'd0;
        cnt_nxt = 4'd0;
        if (start) begin
          acc_nxt   = '0;
          state_nxt = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = 4'd0;
          state_nxt = S_SAMPLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_SAMPLE: begin
        acc_nxt[si] = y;
        // Last channel goes straight to dout; acc would lag by one cycle.
        if (si == 4'd15) begin
          dout_nxt  = {y, acc[14:0]};
          state_nxt = S_DONE;
        end else begin
          si_nxt    = si + 4'd1;
          state_nxt = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
        end
      end
      S_DONE: begin
        if (dn.ready) begin
          si_nxt    = 4'd0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign dn.dout  = dout_q;
  assign dn.valid = (state == S_DONE);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: table-driven scans, hand-written reset corners and
// randomized scans checked against a timing-formula model, on SETTLE=1 and 0.
module tb_mux_scan_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start1 = 1'b0, start0 = 1'b0;
  logic        ready1 = 1'b0, ready0 = 1'b0;
  logic [15:0] data1 = '0, data0 = '0;
  logic        y1, y0, busy1, busy0;
  logic [3:0]  si1, si0;

  mux_scan_seq_if if1 ();
  mux_scan_seq_if if0 ();

  assign if1.ready = ready1;
  assign if0.ready = ready0;
  assign y1 = data1[si1];
  assign y0 = data0[si0];

  mux_scan_seq #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .y(y1), .si(si1), .busy(busy1), .dn(if1)
  );
  mux_scan_seq #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .y(y0), .si(si0), .busy(busy0), .dn(if0)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          w;          // 0: SETTLE=1 instance, 1: SETTLE=0 instance
    logic [15:0] d1;
    int          sw_ch;      // data switches to d2 after this channel's sample; 16 = never
    logic [15:0] d2;
    int          stall;
    bit          mid_start;
    bit          start_at_xfer;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] g_si(input bit w);
    return w ? si0 : si1;
  endfunction
  function automatic logic g_valid(input bit w);
    return w ? if0.valid : if1.valid;
  endfunction
  function automatic logic g_busy(input bit w);
    return w ? busy0 : busy1;
  endfunction
  function automatic logic [15:0] g_dout(input bit w);
    return w ? if0.dout : if1.dout;
  endfunction

  task automatic set_start(input bit w, input logic v);
    if (w) start0 = v; else start1 = v;
  endtask
  task automatic set_ready(input bit w, input logic v);
    if (w) ready0 = v; else ready1 = v;
  endtask
  task automatic set_data(input bit w, input logic [15:0] v);
    if (w) data0 = v; else data1 = v;
  endtask

  // Called at #1 after a rising edge with the selected instance in IDLE.
  task automatic run_scan(input bit w, input logic [15:0] d1, input int sw_ch,
                          input logic [15:0] d2, input int stall, input bit mid_start,
                          input bit start_at_xfer, input bit rnd_ready,
                          input logic [15:0] exp, input string tag);
    int          p    = w ? 1 : 2;
    int          last = 16 * p;
    int          ch;
    logic [15:0] model = '0;
    logic [15:0] cur   = d1;
    logic [15:0] held;
    set_data(w, d1);
    set_ready(w, 1'b0);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    check({tag, " busy_e0"}, 32'(g_busy(w)), 32'd1);
    for (int k = 1; k <= last; k++) begin
      if (k % p == 0) begin
        ch = k / p - 1;
        model[ch] = cur[ch];
      end
      @(posedge clk); #1;
      if (sw_ch < 16 && k == (sw_ch + 1) * p) begin
        cur = d2;
        set_data(w, d2);
      end
      set_start(w, mid_start && k == 5);
      if (rnd_ready && k < last) set_ready(w, 1'($urandom_range(0, 1)));
      check({tag, " si"}, 32'(g_si(w)), (k / p > 15) ? 32'd15 : 32'(k / p));
      check({tag, " valid"}, 32'(g_valid(w)), 32'(k == last));
      check({tag, " busy"}, 32'(g_busy(w)), 32'd1);
    end
    check({tag, " dout_model"}, 32'(g_dout(w)), 32'(model));
    check({tag, " dout_exp"}, 32'(g_dout(w)), 32'(exp));
    held = g_dout(w);
    for (int i = 0; i < stall; i++) begin
      set_ready(w, 1'b0);
      @(posedge clk); #1;
      check({tag, " stall_valid"}, 32'(g_valid(w)), 32'd1);
      check({tag, " stall_dout"}, 32'(g_dout(w)), 32'(held));
      check({tag, " stall_si"}, 32'(g_si(w)), 32'd15);
    end
    set_ready(w, 1'b1);
    set_start(w, start_at_xfer);
    @(posedge clk); #1;
    set_ready(w, 1'b0);
    set_start(w, 1'b0);
    check({tag, " xfer_valid"}, 32'(g_valid(w)), 32'd0);
    check({tag, " xfer_busy"}, 32'(g_busy(w)), 32'd0);
    check({tag, " xfer_si"}, 32'(g_si(w)), 32'd0);
    check({tag, " xfer_dout"}, 32'(g_dout(w)), 32'(held));
  endtask

  initial begin
    bit          bad;
    bit          hit;
    logic [15:0] rd1, rd2, rexp;
    int          rsw;
    bit          rw;

    tbl[0] = '{w: 1'b0, d1: 16'hA5C3, sw_ch: 16, d2: 16'hA5C3, stall: 10,
               mid_start: 1'b0, start_at_xfer: 1'b0, exp: 16'hA5C3};
    tbl[1] = '{w: 1'b0, d1: 16'hFFFF, sw_ch: 7, d2: 16'h0000, stall: 0,
               mid_start: 1'b1, start_at_xfer: 1'b1, exp: 16'h00FF};
    tbl[2] = '{w: 1'b1, d1: 16'h8001, sw_ch: 16, d2: 16'h8001, stall: 2,
               mid_start: 1'b0, start_at_xfer: 1'b0, exp: 16'h8001};
    tbl[3] = '{w: 1'b1, d1: 16'hFFFF, sw_ch: 3, d2: 16'h0000, stall: 1,
               mid_start: 1'b1, start_at_xfer: 1'b1, exp: 16'h000F};
    tbl[4] = '{w: 1'b0, d1: 16'h0000, sw_ch: 14, d2: 16'hFFFF, stall: 3,
               mid_start: 1'b0, start_at_xfer: 1'b0, exp: 16'h8000};

    #1;
    for (int w = 0; w < 2; w++) begin
      check("rst_si", 32'(g_si(1'(w))), 32'd0);
      check("rst_dout", 32'(g_dout(1'(w))), 32'd0);
      check("rst_valid", 32'(g_valid(1'(w))), 32'd0);
      check("rst_busy", 32'(g_busy(1'(w))), 32'd0);
    end
    #12 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++)
      run_scan(tbl[i].w, tbl[i].d1, tbl[i].sw_ch, tbl[i].d2, tbl[i].stall,
               tbl[i].mid_start, tbl[i].start_at_xfer, 1'b0, tbl[i].exp, $sformatf("tbl%0d", i));

    // Asynchronous reset while DONE holds a word: outputs clear between edges.
    data1  = 16'h5A5A;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(posedge clk); #1;
      hit = if1.valid;
    end
    check("async_reach_done", 32'(hit), 32'd1);
    check("async_pre_dout", 32'(if1.dout), 32'h5A5A);
    #2 rst = 1'b1;
    #1;
    check("async_si", 32'(si1), 32'd0);
    check("async_dout", 32'(if1.dout), 32'd0);
    check("async_valid", 32'(if1.valid), 32'd0);
    check("async_busy", 32'(busy1), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-scan at si=9, then a fresh scan.
    data1  = 16'hFFFF;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (si1 == 4'd9) hit = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("mid_reach_si9", 32'(hit), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_si", 32'(si1), 32'd0);
    check("mid_dout", 32'(if1.dout), 32'd0);
    check("mid_valid", 32'(if1.valid), 32'd0);
    check("mid_busy", 32'(busy1), 32'd0);
    #1 rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (if1.valid !== 1'b0 || busy1 !== 1'b0 || si1 !== 4'd0) bad = 1'b1;
    end
    check("mid_stays_idle", 32'(bad), 32'd0);
    run_scan(1'b0, 16'h1234, 16, 16'h1234, 0, 1'b0, 1'b0, 1'b0, 16'h1234, "post_rst");

    // Randomized scans; expected word follows directly from the switch channel.
    for (int n = 0; n < 24; n++) begin
      rw  = 1'($urandom_range(0, 1));
      rd1 = 16'($urandom);
      rd2 = 16'($urandom);
      rsw = int'($urandom_range(0, 16));
      for (int c = 0; c < 16; c++) rexp[c] = (c <= rsw) ? rd1[c] : rd2[c];
      run_scan(rw, rd1, rsw, rd2, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b1, rexp, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
